// File: rtl/proc_pkg.sv
// Shared definitions for the 10-bit processor and its program feeder.
package proc_pkg;

    // Processor data bus width
    localparam int unsigned WIDTH = 10;

    // Feeder control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } feeder_state_t;

    // Instruction word layout: [9:7] opcode, [6:4] rx, [3:1] ry, [0] unused
    localparam int unsigned OPC_MSB = 9;
    localparam int unsigned OPC_LSB = 7;

    localparam logic [2:0] OP_LD  = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_MV  = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    // Assemble one instruction word from its fields
    function automatic logic [WIDTH-1:0] asm_instr(input logic [2:0] op,
                                                   input logic [2:0] rx,
                                                   input logic [2:0] ry);
        return {op, rx, ry, 1'b0};
    endfunction

endpackage

// File: rtl/prog_mem.sv
// Program store: register array, synchronous write, asynchronous read, async clear.
module prog_mem #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Clear every word on reset, otherwise store on write strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_feeder.sv
// Program feeder: loads a small program while idle, then presents one word per
// processor consume until the last loaded word has been taken.
module program_feeder #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned WIDTH = 10
) (
    input  logic             CLKb,
    input  logic             RSTn,
    input  logic             WR_EN,
    input  logic [AW-1:0]    WR_ADDR,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic [AW:0]      LEN_IN,
    input  logic             START,
    input  logic             ABORT,
    input  logic             CONSUME,
    output logic [WIDTH-1:0] D_OUT,
    output logic [AW-1:0]    PC,
    output logic             RUNNING,
    output logic             HALTED
);

    import proc_pkg::*;

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    feeder_state_t    state_q;
    logic [AW-1:0]    pc_q;
    logic [AW:0]      len_q;
    logic             running_q;
    logic             halted_q;

    logic [AW:0]      len_clamped;
    logic [AW:0]      last_idx;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rdata;

    assign len_clamped = (LEN_IN > DEPTH_L) ? DEPTH_L : LEN_IN;
    assign last_idx    = len_q - (AW + 1)'(1);

    // Loads only while idle; ABORT outranks a write on the same edge
    assign mem_we = WR_EN && !ABORT && (state_q == IDLE) && ({1'b0, WR_ADDR} < DEPTH_L);

    prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (WIDTH)
    ) u_prog_mem (
        .clk_i   (CLKb),
        .rst_ni  (RSTn),
        .we_i    (mem_we),
        .waddr_i (WR_ADDR),
        .wdata_i (WR_DATA),
        .raddr_i (pc_q),
        .rdata_o (mem_rdata)
    );

    // Control FSM with PC, length and registered status flags
    always_ff @(posedge CLKb or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            len_q     <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else if (ABORT) begin
            // Memory and length are kept so START alone reruns the program
            state_q   <= IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        len_q <= len_clamped;
                        pc_q  <= '0;
                        if (len_clamped != '0) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end else begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (CONSUME) begin
                        if ({1'b0, pc_q} == last_idx) begin
                            // PC stays on the last word; no wrap
                            state_q   <= HALT;
                            running_q <= 1'b0;
                            halted_q  <= 1'b1;
                        end else begin
                            pc_q <= pc_q + AW'(1);
                        end
                    end
                end
                HALT: begin
                end
                default: begin
                    state_q   <= IDLE;
                    pc_q      <= '0;
                    running_q <= 1'b0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

    // Word is only driven while running; zero in IDLE, HALT and reset
    assign D_OUT   = running_q ? mem_rdata : '0;
    assign PC      = pc_q;
    assign RUNNING = running_q;
    assign HALTED  = halted_q;

endmodule

// File: tb/tb_program_feeder.sv
// Directed bench for program_feeder.
module tb_program_feeder;

    localparam int AW    = 5;
    localparam int WIDTH = 10;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW:0]      len_in;
    logic             start;
    logic             abort;
    logic             consume;
    logic [WIDTH-1:0] d_out;
    logic [AW-1:0]    pc;
    logic             running;
    logic             halted;

    int errors = 0;
    int checks = 0;

    program_feeder #(
        .DEPTH (32),
        .AW    (AW),
        .WIDTH (WIDTH)
    ) dut (
        .CLKb    (clk),
        .RSTn    (rst_n),
        .WR_EN   (wr_en),
        .WR_ADDR (wr_addr),
        .WR_DATA (wr_data),
        .LEN_IN  (len_in),
        .START   (start),
        .ABORT   (abort),
        .CONSUME (consume),
        .D_OUT   (d_out),
        .PC      (pc),
        .RUNNING (running),
        .HALTED  (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_start(input logic [AW:0] n);
        start  = 1'b1;
        len_in = n;
        tick();
        start  = 1'b0;
    endtask

    task automatic do_consume();
        consume = 1'b1;
        tick();
        consume = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        len_in  = '0;
        start   = 1'b0;
        abort   = 1'b0;
        consume = 1'b0;

        // Reset for two cycles
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_dout", 16'(d_out), 16'h000);
        chk("rst_pc", 16'(pc), 16'd0);
        chk("rst_running", 16'(running), 16'd0);
        chk("rst_halted", 16'(halted), 16'd0);

        // Whole memory reads back as zero after reset
        do_start(6'd32);
        for (int i = 0; i < 32; i++) begin
            chk("clr_dout", 16'(d_out), 16'h000);
            chk("clr_pc", 16'(pc), 16'(i));
            chk("clr_running", 16'(running), 16'd1);
            do_consume();
        end
        chk("clr_halted", 16'(halted), 16'd1);
        chk("clr_pc_end", 16'(pc), 16'd31);
        do_abort();
        chk("abort_idle_running", 16'(running), 16'd0);
        chk("abort_idle_halted", 16'(halted), 16'd0);
        chk("abort_idle_pc", 16'(pc), 16'd0);

        // Load three words and run with a consume every fourth cycle
        write_word(5'd0, 10'h041);
        write_word(5'd1, 10'h1A5);
        write_word(5'd2, 10'h2C0);
        chk("idle_dout", 16'(d_out), 16'h000);
        do_start(6'd3);
        chk("run0_dout", 16'(d_out), 16'h041);
        chk("run0_pc", 16'(pc), 16'd0);
        chk("run0_running", 16'(running), 16'd1);
        repeat (3) tick();
        chk("run0_hold_dout", 16'(d_out), 16'h041);
        do_consume();
        chk("run1_dout", 16'(d_out), 16'h1A5);
        chk("run1_pc", 16'(pc), 16'd1);

        // Stall for ten cycles at PC=1
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_dout", 16'(d_out), 16'h1A5);
            chk("stall_pc", 16'(pc), 16'd1);
        end
        do_consume();
        chk("run2_dout", 16'(d_out), 16'h2C0);
        chk("run2_pc", 16'(pc), 16'd2);
        repeat (3) tick();
        do_consume();
        chk("halt_halted", 16'(halted), 16'd1);
        chk("halt_running", 16'(running), 16'd0);
        chk("halt_dout", 16'(d_out), 16'h000);
        chk("halt_pc", 16'(pc), 16'd2);

        // HALT ignores consume and start
        do_consume();
        do_start(6'd3);
        chk("halt_sticky", 16'(halted), 16'd1);
        chk("halt_sticky_pc", 16'(pc), 16'd2);

        // Rerun with START alone after ABORT; write during RUN ignored
        do_abort();
        do_start(6'd3);
        chk("rerun_dout", 16'(d_out), 16'h041);
        write_word(5'd0, 10'h3FF);
        do_consume();
        do_consume();
        chk("rerun_pc2", 16'(pc), 16'd2);
        do_abort();
        chk("abort_run_pc", 16'(pc), 16'd0);
        chk("abort_run_dout", 16'(d_out), 16'h000);
        do_start(6'd3);
        chk("after_abort_pc", 16'(pc), 16'd0);
        chk("after_abort_dout", 16'(d_out), 16'h041);

        // Zero length goes straight to HALT
        do_abort();
        do_start(6'd0);
        chk("zero_running", 16'(running), 16'd0);
        chk("zero_halted", 16'(halted), 16'd1);
        chk("zero_dout", 16'(d_out), 16'h000);

        // Length above depth is clamped to 32
        do_abort();
        do_start(6'd40);
        for (int i = 0; i < 31; i++) do_consume();
        chk("clamp_pc31", 16'(pc), 16'd31);
        chk("clamp_running31", 16'(running), 16'd1);
        do_consume();
        chk("clamp_halted", 16'(halted), 16'd1);
        chk("clamp_pc_hold", 16'(pc), 16'd31);

        // Write and START on the same edge: word visible in RUN
        do_abort();
        wr_en   = 1'b1;
        wr_addr = 5'd1;
        wr_data = 10'h155;
        do_start(6'd3);
        wr_en   = 1'b0;
        chk("same_edge_dout0", 16'(d_out), 16'h041);
        do_consume();
        chk("same_edge_dout1", 16'(d_out), 16'h155);

        // Asynchronous reset mid-RUN
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dout", 16'(d_out), 16'h000);
        chk("async_rst_running", 16'(running), 16'd0);
        chk("async_rst_pc", 16'(pc), 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_start(6'd3);
        chk("post_rst_mem0", 16'(d_out), 16'h000);
        do_consume();
        chk("post_rst_mem1", 16'(d_out), 16'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
